// File: rtl/sha2_padder.sv
// rtl/sha2_padder.sv - SHA-2 message padder feeding 16-word blocks to the message schedule
//
// Turns a stream of big-endian message words into padded SHA-2 blocks:
// message words, a 0x80 marker byte, zero fill, then the 2*WIDTH-bit
// message bit length in the last two words of the final block.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous active-low reset
//   in_data    message word, first byte in the MSBs
//   in_bytes   valid bytes in in_data (MSB-aligned); 0 only with in_last
//   in_last    final message word
//   in_valid   input word valid
//   in_ready   padder accepts a word this cycle (registered)
//   blk_ack    downstream ready for the next 16-word block
//   out_data   padded word
//   out_load   out_data valid
//   out_block  pulse with word 15 of every block
//   out_done   pulse with word 15 of the final block
//   err        (only with SHA2_PADDER_ERR_EN) sticky input/length error
//
// Build option: define SHA2_PADDER_ERR_EN to add the err output.

module sha2_padder #(
    parameter int WIDTH = 32,
    parameter int MODE  = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [$clog2(WIDTH/8):0]   in_bytes,
    input  logic                       in_last,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       blk_ack,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_load,
    output logic                       out_block,
`ifdef SHA2_PADDER_ERR_EN
    output logic                       out_done,
    output logic                       err
`else
    output logic                       out_done
`endif
);

    localparam int NB = WIDTH / 8;
    localparam int BW = $clog2(NB) + 1;
    localparam int LW = 2 * WIDTH;

    // MODE only names the digest; WIDTH alone sets the datapath. Legal
    // pairings are 32/224, 32/256, 64/384 and 64/512.
    if (!((WIDTH == 32 && (MODE == 224 || MODE == 256)) ||
          (WIDTH == 64 && (MODE == 384 || MODE == 512)))) begin : g_unsupported_mode
    end

    typedef enum logic [2:0] {IDLE, MSG, PAD80, PADZ, LENHI, LENLO, WAIT} state_t;

    state_t          state;
    state_t          saved;
    logic [3:0]      idx;
    logic [LW-1:0]   len;

    logic            accept;
    logic            partial;
    logic [LW:0]     len_sum;
    logic [WIDTH-1:0] pad_word;
    logic            emit;
    logic [WIDTH-1:0] word;
    state_t          follow;

    assign accept  = in_valid & in_ready;
    assign partial = in_bytes < BW'(NB);
    // Extra top bit is the carry out, i.e. length overflow.
    assign len_sum = {1'b0, len} + (LW + 1)'({in_bytes, 3'b000});

    // Keep the valid bytes, put 0x80 right after them, clear the rest.
    always_comb begin
        pad_word = '0;
        for (int i = 0; i < NB; i++) begin
            if (BW'(i) < in_bytes)
                pad_word[WIDTH-1-8*i -: 8] = in_data[WIDTH-1-8*i -: 8];
            else if (BW'(i) == in_bytes)
                pad_word[WIDTH-1-8*i -: 8] = 8'h80;
        end
    end

    // Word emitted this cycle and the state that follows it. Once the
    // 0x80 has gone out, index 13 is the last slot before the length
    // pair; anything later rolls the length into a fresh block.
    always_comb begin
        emit   = 1'b0;
        word   = '0;
        follow = state;
        case (state)
            IDLE, MSG: begin
                emit = accept;
                if (!in_last) begin
                    word   = in_data;
                    follow = MSG;
                end else if (partial) begin
                    word   = pad_word;
                    follow = (idx == 4'd13) ? LENHI : PADZ;
                end else begin
                    word   = in_data;
                    follow = PAD80;
                end
            end
            PAD80: begin
                emit   = 1'b1;
                word   = {8'h80, {(WIDTH-8){1'b0}}};
                follow = (idx == 4'd13) ? LENHI : PADZ;
            end
            PADZ: begin
                emit   = 1'b1;
                follow = (idx == 4'd13) ? LENHI : PADZ;
            end
            LENHI: begin
                emit   = 1'b1;
                word   = len[LW-1:WIDTH];
                follow = LENLO;
            end
            LENLO: begin
                emit   = 1'b1;
                word   = len[WIDTH-1:0];
                follow = IDLE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            saved     <= IDLE;
            idx       <= 4'd0;
            len       <= '0;
            out_data  <= '0;
            out_load  <= 1'b0;
            out_block <= 1'b0;
            out_done  <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            out_load  <= 1'b0;
            out_block <= 1'b0;
            out_done  <= 1'b0;
            if (accept)
                len <= len_sum[LW-1:0];
            if (state == WAIT) begin
                in_ready <= 1'b0;
                if (blk_ack) begin
                    state    <= saved;
                    in_ready <= (saved == IDLE) || (saved == MSG);
                    if (saved == IDLE) begin
                        len <= '0;
                        idx <= 4'd0;
                    end
                end
            end else if (emit) begin
                out_data <= word;
                out_load <= 1'b1;
                idx      <= idx + 4'd1;
                if (idx == 4'd15) begin
                    state     <= WAIT;
                    saved     <= follow;
                    out_block <= 1'b1;
                    out_done  <= (state == LENLO);
                    in_ready  <= 1'b0;
                end else begin
                    state    <= follow;
                    in_ready <= (follow == IDLE) || (follow == MSG);
                end
            end else begin
                in_ready <= (state == IDLE) || (state == MSG);
            end
        end
    end

`ifdef SHA2_PADDER_ERR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            err <= 1'b0;
        else if (accept && ((in_bytes > BW'(NB)) ||
                            (in_bytes == '0 && !in_last) ||
                            len_sum[LW]))
            err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_sha2_padder.sv
// tb/tb_sha2_padder.sv - scoreboard bench for sha2_padder (WIDTH=32) against a byte-level SHA-256 padding model

module tb_sha2_padder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic [2:0]  in_bytes;
    logic        in_last;
    logic        in_valid;
    logic        in_ready;
    logic        blk_ack;
    logic [31:0] out_data;
    logic        out_load;
    logic        out_block;
    logic        out_done;
`ifdef SHA2_PADDER_ERR_EN
    logic        err;
`endif

    sha2_padder #(.WIDTH(32), .MODE(256)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_bytes  (in_bytes),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .blk_ack   (blk_ack),
        .out_data  (out_data),
        .out_load  (out_load),
        .out_block (out_block),
`ifdef SHA2_PADDER_ERR_EN
        .out_done  (out_done),
        .err       (err)
`else
        .out_done  (out_done)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        bit          blk;
        bit          done;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference: standard SHA-256 padding on a byte array, cut into words.
    task automatic push_expected(input byte unsigned msg[$]);
        byte unsigned p[$];
        longint unsigned bits;
        int nw;
        exp_t e;
        p    = msg;
        bits = longint'(msg.size()) * 8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(8'(bits >> (8 * i)));
        nw = p.size() / 4;
        for (int w = 0; w < nw; w++) begin
            e.data = {p[4*w], p[4*w+1], p[4*w+2], p[4*w+3]};
            e.blk  = (w % 16 == 15);
            e.done = (w == nw - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic drive_word(input logic [31:0] d, input logic [2:0] b, input logic l);
        int cnt;
        @(negedge clk);
        in_data  = d;
        in_bytes = b;
        in_last  = l;
        in_valid = 1'b1;
        cnt = 0;
        while (!in_ready && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 0, 1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic send_msg(input byte unsigned msg[$]);
        int n, nw, nb;
        logic [31:0] d;
        push_expected(msg);
        n  = msg.size();
        nw = (n == 0) ? 1 : (n + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            nb = (w == nw - 1) ? n - 4 * w : 4;
            d  = $urandom;
            for (int k = 0; k < nb; k++) d[31-8*k -: 8] = msg[4*w+k];
            repeat ($urandom_range(0, 2)) @(negedge clk);
            drive_word(d, 3'(nb), w == nw - 1);
        end
    endtask

    task automatic drain;
        int cnt;
        cnt = 0;
        while (exp_q.size() != 0 && cnt < 3000) begin
            @(negedge clk);
            cnt++;
        end
        check("drain_remaining", exp_q.size(), 0);
    endtask

    task automatic send_random(input int n);
        byte unsigned m[$];
        for (int i = 0; i < n; i++) m.push_back(8'($urandom));
        send_msg(m);
        drain();
    endtask

    // Monitor: every out_load pops one expected word.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (out_load) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: got 0x%0h, expected no word", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", out_data, e.data);
                        check("out_block", out_block, e.blk);
                        check("out_done", out_done, e.done);
                    end
                end else if (out_block || out_done) begin
                    check("pulse_without_load", {out_block, out_done}, 0);
                end
            end
        end
    end

    // Block acknowledge: random stall after each out_block, random noise otherwise.
    initial begin
        int d;
        blk_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && out_block) begin
                d = $urandom_range(0, 6);
                blk_ack = 1'b0;
                repeat (d) begin
                    @(negedge clk);
                    check("wait_in_ready", in_ready, 0);
                    check("wait_out_load", out_load, 0);
                end
                blk_ack = 1'b1;
            end else begin
                blk_ack = ($urandom_range(0, 3) == 0);
            end
        end
    end

    initial begin
        byte unsigned m[$];
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_bytes = '0;
        in_last  = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_out_data", out_data, 0);
        check("reset_out_load", out_load, 0);
        check("reset_out_block", out_block, 0);
        check("reset_out_done", out_done, 0);
        check("reset_in_ready", in_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_reset", in_ready, 1);

        m = '{8'h61, 8'h62, 8'h63};
        send_msg(m);
        drain();
        m = '{};
        send_msg(m);
        drain();
        foreach (m[i]) m.delete(i);
        send_random(56);
        send_random(55);
        send_random(60);
        send_random(63);
        send_random(64);
        send_random(52);
        send_random(119);
        send_random(128);
        for (int r = 0; r < 20; r++) send_random($urandom_range(0, 150));

        // Reset in the middle of a block: 8 message words, then rst.
        for (int w = 0; w < 8; w++) begin
            exp_t e;
            e.data = $urandom;
            e.blk  = 1'b0;
            e.done = 1'b0;
            exp_q.push_back(e);
            drive_word(e.data, 3'd4, 1'b0);
        end
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_rst_out_load", out_load, 0);
        check("async_rst_out_data", out_data, 0);
        check("async_rst_out_block", out_block, 0);
        check("async_rst_in_ready", in_ready, 0);
        repeat (2) @(negedge clk);
        check("partial_block_emitted", exp_q.size(), 0);
        exp_q.delete();
        rst = 1'b1;
        #1 check("ready_low_at_release", in_ready, 0);
        @(negedge clk);
        check("ready_high_after_release", in_ready, 1);
        m = '{8'h61, 8'h62, 8'h63};
        send_msg(m);
        drain();

`ifdef SHA2_PADDER_ERR_EN
        check("err_clear", err, 0);
        begin
            exp_t e;
            e.data = 32'h1234_5678;
            e.blk  = 1'b0;
            e.done = 1'b0;
            exp_q.push_back(e);
            drive_word(e.data, 3'd5, 1'b0);
        end
        @(negedge clk);
        check("err_set", err, 1);
        repeat (4) @(negedge clk);
        check("err_sticky", err, 1);
        rst = 1'b0;
        #1 check("err_reset", err, 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
`endif

        repeat (5) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/sha2_padder.md
SHA2_PADDER -- requirements
Module: sha2_padder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, word width in bits (32 for SHA-224/256, 64 for SHA-384/512).
REQ-002 SHALL have parameter MODE, default 256, digest mode (224/256/384/512); the length field is 2*WIDTH bits.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port in_data  input  WIDTH  message word, big-endian (first byte in MSBs).
REQ-006 SHALL have port in_bytes  input  $clog2(WIDTH/8)+1  valid bytes in in_data, MSB-aligned; 0 allowed only with in_last.
REQ-007 SHALL have port in_last  input  1  marks the final message word.
REQ-008 SHALL have port in_valid  input  1  in_data/in_bytes/in_last valid.
REQ-009 SHALL have port in_ready  output  1  padder accepts a word this cycle.
REQ-010 SHALL have port blk_ack  input  1  schedule/core ready for the next 16-word block.
REQ-011 SHALL have port out_data  output  WIDTH  padded word, drives the schedule's data_in.
REQ-012 SHALL have port out_load  output  1  out_data valid; drives the schedule's load.
REQ-013 SHALL have port out_block  output  1  one-cycle pulse with word 15 of every block.
REQ-014 SHALL have port out_done  output  1  one-cycle pulse with word 15 of the final block.

Function
REQ-015 SHALL implement states IDLE, MSG, PAD80, PADZ, LENHI, LENLO, WAIT.
REQ-016 SHALL assert in_ready only in IDLE and MSG; a word transfers when in_valid & in_ready.
REQ-017 SHALL register outputs: a word accepted in cycle N appears with out_load=1 in cycle N+1; at most one word per cycle.
REQ-018 SHALL keep a 4-bit word index, incremented on every out_load, wrapping 15->0.
REQ-019 SHALL keep a 2*WIDTH-bit bit-length counter, adding 8*in_bytes per accepted word, wrapping modulo 2^(2*WIDTH).
REQ-020 On a non-last word: out_data=in_data unchanged; IDLE->MSG.
REQ-021 On last with in_bytes<WIDTH/8: byte at index in_bytes SHALL be 0x80, lower bytes 0; next state PADZ.
REQ-022 On last with in_bytes=WIDTH/8: word emitted unchanged; next state PAD80, which emits 0x80 followed by zero bytes, then PADZ.
REQ-023 PADZ SHALL emit zero words until index 14 is next, then LENHI emits length[2W-1:W] at index 14, LENLO emits length[W-1:0] at index 15.
REQ-024 If the 0x80 word lands at index 14 or 15, PADZ SHALL zero-fill to 15, wait, then emit 14 zero words of a new block before LENHI/LENLO.
REQ-025 After index-15 word: pulse out_block, enter WAIT (in_ready=0, out_load=0) until blk_ack=1, then resume saved state (MSG, PAD80, PADZ) or, after LENLO, return to IDLE.
REQ-026 blk_ack SHALL be ignored outside WAIT; WAIT with blk_ack already high lasts exactly one cycle.
REQ-027 After final block and blk_ack, length counter and index SHALL clear to 0 for the next message.
REQ-028 out_done SHALL coincide with out_block on the LENLO word only.

Reset
REQ-029 rst low SHALL immediately force IDLE, index 0, length 0, out_data 0, out_load 0, out_block 0, out_done 0, in_ready 0 while low; in_ready 1 from first edge after release.
REQ-030 Reset mid-block SHALL discard the partial block; no pulse on out_block/out_done.

Configuration
REQ-031 With SHA2_PADDER_ERR_EN defined, SHALL add output err (1 bit, reset 0), set sticky on accepted in_bytes>WIDTH/8, in_bytes=0 without in_last, or length counter overflow; cleared only by reset.
REQ-032 Without SHA2_PADDER_ERR_EN, err port and checks SHALL be absent; behaviour otherwise identical.

Verification
REQ-033 WIDTH=32: "abc" (0x61626300, bytes=3, last) -> word0 0x61626380, words1-14 0, word15 0x00000018, out_done with word15.
REQ-034 Empty message (bytes=0, last) -> word0 0x80000000, words1-15 0, out_done.
REQ-035 14 full words, last full -> block1 word14 0x80000000, word15 0, out_block; after blk_ack, block2 words0-14 0, word15 0x000001C0, out_done.
REQ-036 blk_ack held low 5 cycles after out_block -> in_ready=0, out_load=0 throughout; resume one cycle after blk_ack.
REQ-037 rst asserted after word 7 -> outputs 0 asynchronously; fresh "abc" then yields REQ-033 result.
REQ-038 SHA2_PADDER_ERR_EN defined, in_bytes=5 accepted -> err=1 next cycle and stays 1 until reset.
